// File: rtl/velocity_cell_mem_ctrl_if.sv
// Bus bundle for velocity_cell_mem_ctrl: consumer stream, write-back request and RAM port.
// The controller takes the master view; the surrounding logic/RAM takes the slave view.
interface velocity_cell_mem_ctrl_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_pid;

    logic                  wb_valid;
    logic                  wb_ready;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;

    modport master (
        output out_valid, out_data, out_pid,
        input  out_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        output mem_address, mem_data, mem_rden, mem_wren,
        input  mem_q
    );

    modport slave (
        input  out_valid, out_data, out_pid,
        output out_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        input  mem_address, mem_data, mem_rden, mem_wren,
        output mem_q
    );
endinterface

// File: rtl/velocity_cell_mem_ctrl.sv
// Cell-pass sequencer and single-port arbiter for the velocity RAM: reads the count, streams
// words 1..count through a 2-entry skid buffer. Define VEL_CTRL_RR_ARB_EN for alternating priority.
module velocity_cell_mem_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] cell_count,
    output logic                  cnt_err,
    velocity_cell_mem_ctrl_if.master bus
);
    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_PID = ADDR_WIDTH'(PARTICLE_NUM - 1);

    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        return (raw > MAX_PID) ? MAX_PID : raw;
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q;
    logic [1:0]            occ_q;
    logic                  rd_vld_p1;
    logic [ADDR_WIDTH-1:0] rd_pid_p1;
    logic [ADDR_WIDTH-1:0] fifo_pid  [2];
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            used;
    logic                  pop, has_credit, rd_req, rd_issue, wr_en, stream_issue;
    logic [ADDR_WIDTH-1:0] cnt_raw;

    // A word popped this cycle frees its slot in time for a new issue, sustaining 1 word/cycle.
    assign pop        = bus.out_valid && bus.out_ready;
    assign used       = occ_q + {1'b0, rd_vld_p1};
    assign has_credit = (used != 2'd2) || pop;
    assign rd_req     = (state_q == RD_CNT) || ((state_q == STREAM) && has_credit);

`ifdef VEL_CTRL_RR_ARB_EN
    logic rd_prio_q;

    assign rd_issue = rd_req && (!bus.wb_valid || rd_prio_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_prio_q <= 1'b0;
        end else if (wr_en) begin
            rd_prio_q <= 1'b1;
        end else if (rd_issue) begin
            rd_prio_q <= 1'b0;
        end
    end
`else
    assign rd_issue = rd_req && !bus.wb_valid;
`endif

    assign bus.wb_ready    = rst_n && !rd_issue;
    assign wr_en           = bus.wb_valid && bus.wb_ready;
    assign stream_issue    = rd_issue && (state_q == STREAM);
    assign bus.mem_rden    = rd_issue;
    assign bus.mem_wren    = wr_en;
    assign bus.mem_address = rd_issue ? ((state_q == RD_CNT) ? '0 : rd_ptr_q)
                                      : (wr_en ? bus.wb_addr : '0);
    assign bus.mem_data    = wr_en ? bus.wb_data : '0;

    assign bus.out_valid = (occ_q != 2'd0);
    assign bus.out_pid   = fifo_pid[0];
    assign bus.out_data  = fifo_data[0];
    assign cnt_raw       = bus.mem_q[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RD_CNT;
            end
            RD_CNT: begin
                busy = 1'b1;
                if (rd_issue) state_d = WAIT_CNT;
            end
            WAIT_CNT: begin
                busy    = 1'b1;
                state_d = (clamp_count(cnt_raw) == '0) ? DONE : STREAM;
            end
            STREAM: begin
                busy = 1'b1;
                if (stream_issue && (rd_ptr_q == cell_count)) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if ((occ_q == 2'd0) && !rd_vld_p1) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p1: stream read in flight; its data enters the skid buffer at the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            cell_count   <= '0;
            cnt_err      <= 1'b0;
            rd_vld_p1    <= 1'b0;
            rd_pid_p1    <= '0;
            occ_q        <= 2'd0;
            fifo_pid[0]  <= '0;
            fifo_pid[1]  <= '0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
        end else begin
            if ((state_q == IDLE) && start) cnt_err <= 1'b0;
            if (state_q == WAIT_CNT) begin
                cell_count <= clamp_count(cnt_raw);
                rd_ptr_q   <= ADDR_WIDTH'(1);
                if (cnt_raw > MAX_PID) cnt_err <= 1'b1;
            end else if (stream_issue) begin
                rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
            end
            rd_vld_p1 <= stream_issue;
            rd_pid_p1 <= rd_ptr_q;
            // Credit keeps occupancy at most 1 whenever a push arrives.
            case ({rd_vld_p1, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        fifo_pid[0]  <= rd_pid_p1;
                        fifo_data[0] <= bus.mem_q;
                    end else begin
                        fifo_pid[1]  <= rd_pid_p1;
                        fifo_data[1] <= bus.mem_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    fifo_pid[0]  <= fifo_pid[1];
                    fifo_data[0] <= fifo_data[1];
                    occ_q        <= occ_q - 2'd1;
                end
                2'b11: begin
                    fifo_pid[0]  <= rd_pid_p1;
                    fifo_data[0] <= bus.mem_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_velocity_cell_mem_ctrl.sv
// Bench for velocity_cell_mem_ctrl: RAM model, vector table of cell passes, scoreboard of
// expected {pid,data} beats, and hand sequences for zero count and mid-pass reset.
module tb_velocity_cell_mem_ctrl;
    localparam int DW = 96;
    localparam int AW = 8;
    localparam int PN = 220;

    typedef struct {
        int raw;
        int rdy_mode;
        int wb_n;
        int exp_cnt;
        int exp_err;
    } vec_t;

    typedef struct {
        logic [AW-1:0] pid;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] cell_count;
    logic          cnt_err;

    velocity_cell_mem_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    velocity_cell_mem_ctrl #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .cell_count(cell_count),
        .cnt_err   (cnt_err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] word_of(input int tag, input int a);
        return {32'(tag), 32'(a * 3 + 5), 32'h5A00_0000 + 32'(a)};
    endfunction

    // Single-port RAM with 1-cycle read latency; load_req refills it for a new pass.
    logic [DW-1:0] ram [256];
    logic          load_req;
    int            load_tag;
    int            load_raw;

    always @(posedge clk) begin
        if (load_req) begin
            ram[0] <= {64'hFEED_0000_0000_0001, 32'(load_raw)};
            for (int a = 1; a < 256; a++) ram[a] <= word_of(load_tag, a);
        end else if (bus.mem_wren) begin
            ram[bus.mem_address] <= bus.mem_data;
        end
        if (bus.mem_rden) bus.mem_q <= ram[bus.mem_address];
    end

    int    total = 0;
    int    bad = 0;
    beat_t exp_q[$];
    int    stream_rd, acc, wr_grants, wb_hi, rd_in_wb, done_cnt;
    int    mon_cyc, first_acc, last_acc;
    logic  hold_prev;
    logic [AW-1:0] prev_pid;
    logic [DW-1:0] prev_data;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        stream_rd = 0; acc = 0; wr_grants = 0; wb_hi = 0; rd_in_wb = 0; done_cnt = 0;
        mon_cyc = 0; first_acc = 0; last_acc = 0; hold_prev = 1'b0;
    endtask

    // Per-cycle observation at the falling edge: invariants plus scoreboard pops.
    task automatic monitor();
        beat_t e;
        logic  acc_now;
        if (!rst_n) begin
            hold_prev = 1'b0;
            return;
        end
        mon_cyc++;
        acc_now = bus.out_valid && bus.out_ready;
        chk("port_rule", 256'(bus.mem_rden && bus.mem_wren), 256'(0));
        if (hold_prev)
            chk("stall_hold", {bus.out_valid, bus.out_pid, bus.out_data}, {1'b1, prev_pid, prev_data});
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_pid  = bus.out_pid;
        prev_data = bus.out_data;
        if (bus.mem_rden && (bus.mem_address != '0)) stream_rd++;
        if (acc_now) acc++;
        chk("outstanding", 256'(stream_rd - acc > 2), 256'(0));
        if (bus.mem_wren) wr_grants++;
        if (bus.wb_valid) wb_hi++;
        if (bus.wb_valid && bus.mem_rden) rd_in_wb++;
        if (done) done_cnt++;
        if (acc_now) begin
            if (acc == 1) first_acc = mon_cyc;
            last_acc = mon_cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: pid %0d accepted, required none", bus.out_pid);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {bus.out_pid, bus.out_data}, {e.pid, e.data});
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ram(input int tag, input int raw);
        load_tag = tag;
        load_raw = raw;
        load_req = 1'b1;
        cycle();
        load_req = 1'b0;
    endtask

    task automatic run_pass(input vec_t v, input int tag);
        beat_t b;
        int    cyc;
        int    settle;
        bit    seen;
        load_ram(tag, v.raw);
        clear_stats();
        for (int a = 1; a <= v.exp_cnt; a++) begin
            b.pid  = AW'(a);
            b.data = word_of(tag, a);
            exp_q.push_back(b);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        chk("cnt_err_clear", 256'(cnt_err), 256'(0));
        seen = 0; settle = 0; cyc = 1;
        while (settle < 3 && cyc < 3000) begin
            bus.out_ready = (v.rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (v.wb_n > 0 && cyc >= 4 && wr_grants < v.wb_n) begin
                bus.wb_valid = 1'b1;
                bus.wb_addr  = (wr_grants == 0) ? AW'(0) : AW'(99 + wr_grants);
                bus.wb_data  = word_of(77, wr_grants);
            end else begin
                bus.wb_valid = 1'b0;
            end
            if (done) seen = 1;
            if (seen) settle++;
            cycle();
            cyc++;
        end
        bus.wb_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL pass_timeout: no done within %0d cycles (tag %0d)", cyc, tag);
        end
        chk("done_once", 256'(done_cnt), 256'(1));
        chk("cell_count", 256'(cell_count), 256'(v.exp_cnt));
        chk("cnt_err", 256'(cnt_err), 256'(v.exp_err));
        chk("beats_left", 256'(exp_q.size()), 256'(0));
        chk("busy_idle", 256'(busy), 256'(0));
        if (v.rdy_mode == 0 && v.wb_n == 0 && v.exp_cnt > 0)
            chk("throughput", 256'(last_acc - first_acc), 256'(v.exp_cnt - 1));
        if (v.wb_n > 0) begin
            chk("wb_grants", 256'(wr_grants), 256'(v.wb_n));
            chk("wb_addr0", ram[0], word_of(77, 0));
            for (int k = 1; k < v.wb_n; k++) chk("wb_land", ram[99 + k], word_of(77, k));
`ifdef VEL_CTRL_RR_ARB_EN
            chk("rr_alternate", 256'(rd_in_wb > 0), 256'(1));
`else
            chk("wb_priority", {32'(wb_hi), 32'(rd_in_wb)}, {32'(v.wb_n), 32'(0)});
`endif
        end
        exp_q.delete();
    endtask

    vec_t vecs[5];
    vec_t v_after;
    int   eb[4];
    int   ed[4];
    int   waited;

    initial begin
        vecs[0] = '{3, 0, 0, 3, 0};
        vecs[1] = '{0, 0, 0, 0, 0};
        vecs[2] = '{250, 0, 0, 219, 1};
        vecs[3] = '{5, 1, 0, 5, 0};
        vecs[4] = '{4, 0, 6, 4, 0};
        v_after = '{5, 0, 0, 5, 0};
        eb = '{1, 1, 0, 0};
        ed = '{0, 0, 1, 0};

        rst_n = 1'b0; start = 1'b0; load_req = 1'b0; load_tag = 0; load_raw = 0;
        bus.out_ready = 1'b1; bus.wb_valid = 1'b1; bus.wb_addr = 8'h55; bus.wb_data = '1;
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, done, cnt_err, cell_count, bus.out_valid, bus.out_pid,
                            bus.out_data, bus.mem_rden, bus.mem_wren, bus.wb_ready,
                            bus.mem_address, bus.mem_data}, '0);
        bus.wb_valid = 1'b0;
        rst_n = 1'b1;
        cycle();

        for (int i = 0; i < 5; i++) run_pass(vecs[i], i + 1);

        // Zero count: done lands three cycles after the start pulse.
        load_ram(20, 0);
        clear_stats();
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("zero_busy", 256'(busy), 256'(eb[i]));
            chk("zero_done", 256'(done), 256'(ed[i]));
            cycle();
        end

        // Reset while pid 2 is presented: everything clears at once, no done follows.
        load_ram(30, 5);
        clear_stats();
        for (int a = 1; a <= 5; a++) begin
            beat_t b;
            b.pid = AW'(a);
            b.data = word_of(30, a);
            exp_q.push_back(b);
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        waited = 0;
        while (!(bus.out_valid && bus.out_pid == AW'(2)) && waited < 50) begin
            cycle();
            waited++;
        end
        if (waited >= 50) begin
            total++;
            bad++;
            $display("FAIL reset_wait: pid 2 not presented within 50 cycles");
        end
        #2;
        rst_n = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_addr = 8'h33; bus.wb_data = '1;
        #1;
        chk("mid_reset_zero", {busy, done, cnt_err, cell_count, bus.out_valid, bus.out_pid,
                               bus.out_data, bus.mem_rden, bus.mem_wren, bus.wb_ready,
                               bus.mem_address, bus.mem_data}, '0);
        bus.wb_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cycle();
            chk("mid_reset_hold", {busy, done}, '0);
        end
        exp_q.delete();
        rst_n = 1'b1;
        cycle();
        chk("post_reset_idle", {busy, done}, '0);
        run_pass(v_after, 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
